// File: rtl/pattern_scan_pkg.sv
// ============================================================================
// Module   : pattern_scan_pkg
// Brief    : Shared FSM encoding and default geometry for the pattern scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pattern_scan_pkg;

  localparam logic [1:0] c_st_idle  = 2'b00;
  localparam logic [1:0] c_st_shift = 2'b01;
  localparam logic [1:0] c_st_done  = 2'b10;

  localparam int c_def_word_w = 8;
  localparam int c_def_pat_w  = 4;
  localparam int c_def_cnt_w  = 4;

endpackage

`default_nettype wire

// File: rtl/pattern_hist.sv
// ============================================================================
// Module   : pattern_hist
// Brief    : Serial history register, valid-bit counter and pattern compare
//            with a Mealy hit output. PATTERN_SCAN_OVERLAP_EN keeps the valid
//            count after a hit so matches may share bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_hist
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = c_def_pat_w
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  output logic             hit
);

  localparam int                  c_vcnt_w = $clog2(PAT_W + 1);
  localparam logic [c_vcnt_w-1:0] c_full   = c_vcnt_w'(PAT_W);

  logic [PAT_W-1:0]    r_hist;
  logic [PAT_W-1:0]    w_hist_next;
  logic [c_vcnt_w-1:0] r_vcnt;
  logic [c_vcnt_w-1:0] w_vcnt_inc;
  logic [c_vcnt_w-1:0] w_vcnt_next;

  generate
    if (PAT_W == 1) begin : g_single
      assign w_hist_next = bit_in;
    end else begin : g_multi
      assign w_hist_next = {r_hist[PAT_W-2:0], bit_in};
    end
  endgenerate

  assign w_vcnt_inc = (r_vcnt == c_full) ? c_full : r_vcnt + 1'b1;
  assign hit        = bit_en && (w_vcnt_inc == c_full) && (w_hist_next == pat);

`ifdef PATTERN_SCAN_OVERLAP_EN
  assign w_vcnt_next = w_vcnt_inc;
`else
  // Restart the fill after a hit so no bit contributes to two matches.
  assign w_vcnt_next = hit ? '0 : w_vcnt_inc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_vcnt <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_vcnt <= '0;
    end else if (bit_en) begin
      r_hist <= w_hist_next;
      r_vcnt <= w_vcnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
// ============================================================================
// Module   : pattern_scan_ctrl
// Brief    : Accepts words over valid/ready, streams them MSB-first through
//            pattern_hist and counts matches per word (saturating, sticky
//            overflow). Build option: PATTERN_SCAN_OVERLAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W = c_def_word_w,
  parameter int PAT_W  = c_def_pat_w,
  parameter int CNT_W  = c_def_cnt_w
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PAT_W-1:0]  pat,
  output logic              busy,
  output logic              match,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              cnt_ovf
);

  generate
    if (PAT_W < 1 || PAT_W > WORD_W) begin : g_bad_pat_w
      $error("pattern_scan_ctrl: PAT_W must satisfy 1 <= PAT_W <= WORD_W");
    end
  endgenerate

  localparam int                  c_idx_w    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(WORD_W - 1);
  localparam logic [CNT_W-1:0]    c_cnt_max  = '1;

  logic [1:0]         r_state;
  logic [WORD_W-1:0]  r_word;
  logic [PAT_W-1:0]   r_pat;
  logic [c_idx_w-1:0] r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               w_accept;
  logic               w_shift;
  logic               w_hit;

  assign w_accept  = (r_state == c_st_idle) && in_valid;
  assign w_shift   = (r_state == c_st_shift);

  assign in_ready  = (r_state == c_st_idle);
  assign busy      = w_shift;
  assign done      = (r_state == c_st_done);
  assign match     = w_hit;
  assign match_cnt = r_cnt;
  assign cnt_ovf   = r_ovf;

  pattern_hist #(
    .PAT_W (PAT_W)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .bit_en (w_shift),
    .bit_in (r_word[r_idx]),
    .pat    (r_pat),
    .hit    (w_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_word  <= '0;
      r_pat   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_word  <= in_word;
            r_pat   <= pat;
            r_idx   <= c_idx_last;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= c_st_shift;
          end
        end
        c_st_shift: begin
          if (w_hit) begin
            if (r_cnt == c_cnt_max) r_ovf <= 1'b1;
            else                    r_cnt <= r_cnt + 1'b1;
          end
          if (r_idx == '0) r_state <= c_st_done;
          else             r_idx   <= r_idx - 1'b1;
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
// ============================================================================
// Module   : tb_pattern_scan_ctrl
// Brief    : Directed self-checking bench; cycle c counts clocks after accept.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_word;
  logic [3:0] pat;
  logic       in_ready, busy, match, done, cnt_ovf;
  logic [3:0] match_cnt;
  logic       s_in_ready, s_busy, s_match, s_done, s_cnt_ovf;
  logic [1:0] s_match_cnt;

  int checks   = 0;
  int failures = 0;

  // Per-cycle observation masks: bit c set when the signal was high in cycle c.
  logic [31:0] mm, dm, bm, rm;
  logic [3:0]  cnt_d;
  logic        ovf_d;
  logic [1:0]  scnt_d;
  logic        sovf_d;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .pat(pat), .busy(busy), .match(match), .done(done),
    .match_cnt(match_cnt), .cnt_ovf(cnt_ovf)
  );

  pattern_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_word(in_word), .pat(pat), .busy(s_busy), .match(s_match), .done(s_done),
    .match_cnt(s_match_cnt), .cnt_ovf(s_cnt_ovf)
  );

  task automatic accept(input logic [7:0] w, input logic [3:0] p);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    pat      = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = ~w;
    pat      = ~p;
  endtask

  task automatic scan(input int ncyc);
    mm = '0; dm = '0; bm = '0; rm = '0;
    cnt_d = 'x; ovf_d = 1'bx; scnt_d = 'x; sovf_d = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      mm[c] = match; dm[c] = done; bm[c] = busy; rm[c] = in_ready;
      if (done) begin
        cnt_d = match_cnt; ovf_d = cnt_ovf; scnt_d = s_match_cnt; sovf_d = s_cnt_ovf;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_word = '0; pat = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match: got %b expected 0", match); end
    checks++; if (match_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
    checks++; if (cnt_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", cnt_ovf); end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    accept(8'b1001_1001, 4'b1001);
    scan(10);
    checks++; if (mm !== 32'h110) begin failures++; $display("FAIL basic_match: got %0h expected 110", mm); end
    checks++; if (dm !== 32'h200) begin failures++; $display("FAIL basic_done: got %0h expected 200", dm); end
    checks++; if (bm !== 32'h1FE) begin failures++; $display("FAIL basic_busy: got %0h expected 1fe", bm); end
    checks++; if (rm !== 32'h400) begin failures++; $display("FAIL basic_ready: got %0h expected 400", rm); end
    checks++; if (cnt_d !== 4'd2) begin failures++; $display("FAIL basic_cnt: got %0d expected 2", cnt_d); end
    checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b expected 0", ovf_d); end
    checks++; if (match_cnt !== 4'd2) begin failures++; $display("FAIL basic_cnt_hold: got %0d expected 2", match_cnt); end
  endtask

  task automatic test_overlap;
    logic [31:0] exp_mm;
    logic [3:0]  exp_cnt;
`ifdef PATTERN_SCAN_OVERLAP_EN
    exp_mm = 32'h090; exp_cnt = 4'd2;
`else
    exp_mm = 32'h010; exp_cnt = 4'd1;
`endif
    accept(8'b1001_0010, 4'b1001);
    scan(10);
    checks++; if (mm !== exp_mm) begin failures++; $display("FAIL overlap_match: got %0h expected %0h", mm, exp_mm); end
    checks++; if (cnt_d !== exp_cnt) begin failures++; $display("FAIL overlap_cnt: got %0d expected %0d", cnt_d, exp_cnt); end
  endtask

  task automatic test_saturation;
    logic [31:0] exp_mm;
    logic [3:0]  exp_cnt;
    logic [1:0]  exp_scnt;
    logic        exp_sovf;
`ifdef PATTERN_SCAN_OVERLAP_EN
    exp_mm = 32'h1F0; exp_cnt = 4'd5; exp_scnt = 2'd3; exp_sovf = 1'b1;
`else
    exp_mm = 32'h110; exp_cnt = 4'd2; exp_scnt = 2'd2; exp_sovf = 1'b0;
`endif
    accept(8'h00, 4'b0000);
    scan(10);
    checks++; if (mm !== exp_mm) begin failures++; $display("FAIL sat_match: got %0h expected %0h", mm, exp_mm); end
    checks++; if (cnt_d !== exp_cnt) begin failures++; $display("FAIL sat_wide_cnt: got %0d expected %0d", cnt_d, exp_cnt); end
    checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL sat_wide_ovf: got %b expected 0", ovf_d); end
    checks++; if (scnt_d !== exp_scnt) begin failures++; $display("FAIL sat_cnt: got %0d expected %0d", scnt_d, exp_scnt); end
    checks++; if (sovf_d !== exp_sovf) begin failures++; $display("FAIL sat_ovf: got %b expected %b", sovf_d, exp_sovf); end
    checks++; if (s_cnt_ovf !== exp_sovf) begin failures++; $display("FAIL sat_ovf_hold: got %b expected %b", s_cnt_ovf, exp_sovf); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] cnts [2];
    int         nd = 0;
    @(negedge clk);
    in_valid = 1'b1; in_word = 8'b0000_0001; pat = 4'b1001;
    @(posedge clk);
    #1 in_word = 8'b0010_0000;
    mm = '0; dm = '0; rm = '0;
    cnts[0] = 'x; cnts[1] = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      mm[c] = match; dm[c] = done; rm[c] = in_ready;
      if (done && nd < 2) begin cnts[nd] = match_cnt; nd++; end
      if (c == 11) in_valid = 1'b0;
    end
    checks++; if (dm !== 32'h0008_0200) begin failures++; $display("FAIL b2b_done: got %0h expected 80200", dm); end
    checks++; if (rm !== 32'h0010_0400) begin failures++; $display("FAIL b2b_ready: got %0h expected 100400", rm); end
    checks++; if (mm !== 32'h0) begin failures++; $display("FAIL b2b_match: got %0h expected 0", mm); end
    checks++; if (cnts[0] !== 4'd0) begin failures++; $display("FAIL b2b_cnt0: got %0d expected 0", cnts[0]); end
    checks++; if (cnts[1] !== 4'd0) begin failures++; $display("FAIL b2b_cnt1: got %0d expected 0", cnts[1]); end
  endtask

  task automatic test_reset_mid(input int rc, input logic [3:0] pre_cnt);
    accept(8'b1001_1001, 4'b1001);
    repeat (rc) @(negedge clk);
    checks++; if (match_cnt !== pre_cnt) begin failures++; $display("FAIL rmid%0d_pre_cnt: got %0d expected %0d", rc, match_cnt, pre_cnt); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid%0d_busy: got %b expected 0", rc, busy); end
    checks++; if (match_cnt !== 4'd0) begin failures++; $display("FAIL rmid%0d_cnt: got %0d expected 0", rc, match_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid%0d_ready: got %b expected 1", rc, in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    scan(12);
    checks++; if (dm !== 32'h0) begin failures++; $display("FAIL rmid%0d_no_done: got %0h expected 0", rc, dm); end
    checks++; if (bm !== 32'h0) begin failures++; $display("FAIL rmid%0d_idle: got %0h expected 0", rc, bm); end
    accept(8'b1001_1001, 4'b1001);
    scan(10);
    checks++; if (mm !== 32'h110) begin failures++; $display("FAIL rmid%0d_next_match: got %0h expected 110", rc, mm); end
    checks++; if (cnt_d !== 4'd2) begin failures++; $display("FAIL rmid%0d_next_cnt: got %0d expected 2", rc, cnt_d); end
  endtask

  task automatic test_stall;
    accept(8'b1001_1001, 4'b1001);
    mm = '0; dm = '0; rm = '0; cnt_d = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mm[c] = match; dm[c] = done; rm[c] = in_ready;
      if (done) cnt_d = match_cnt;
      if (c == 3) begin in_valid = 1'b1; in_word = 8'hFF; pat = 4'b1111; end
      if (c == 4) in_valid = 1'b0;
    end
    checks++; if (rm !== 32'h400) begin failures++; $display("FAIL stall_ready: got %0h expected 400", rm); end
    checks++; if (mm !== 32'h110) begin failures++; $display("FAIL stall_match: got %0h expected 110", mm); end
    checks++; if (dm !== 32'h200) begin failures++; $display("FAIL stall_done: got %0h expected 200", dm); end
    checks++; if (cnt_d !== 4'd2) begin failures++; $display("FAIL stall_cnt: got %0d expected 2", cnt_d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_saturation();
    test_back_to_back();
    test_reset_mid(3, 4'd0);
    test_reset_mid(6, 4'd1);
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
